dmem_responder: RTL and testbench

//  Data-memory responder for the core's data port (memAdr/memwrData/memWE in, memrdData out).

---
 rtl/dmem_responder.sv | 141 ++++++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data RAM for the core's data port: registered read, post-reset zero fill,
// sticky range/alignment flags. Define DMEM_MMIO_EN to add the HOST/CYCLE registers at the top of memory.
module dmem_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int INIT_CLEAR = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] memAdr,
  input  logic [DATA_WIDTH-1:0] memwrData,
  input  logic                  memWE,
  output logic [DATA_WIDTH-1:0] memrdData,
  output logic                  ready,
  output logic                  err_range,
  output logic                  err_align,
  output logic                  halt,
  output logic [DATA_WIDTH-1:0] halt_code
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                  state, state_next;
  logic [DEPTH_LOG2-1:0]   clr_idx, clr_idx_next;
  logic [DEPTH_LOG2-1:0]   word_idx;
  logic                    in_ram, misaligned, active;
  logic                    host_hit, cycle_hit, mmio_hit;
  logic                    ram_we;
  logic [DEPTH_LOG2-1:0]   ram_waddr;
  logic [DATA_WIDTH-1:0]   ram_wdata;
  logic [DATA_WIDTH-1:0]   ram [DEPTH];
  logic [DATA_WIDTH-1:0]   ram_q;
  logic [DATA_WIDTH-1:0]   mmio_rd, mmio_q;
  logic                    sel_ram, sel_mmio;

  assign word_idx   = memAdr[DEPTH_LOG2+1:2];
  assign in_ram     = (memAdr[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);
  assign misaligned = |memAdr[1:0];
  assign active     = (state == READY);
  assign mmio_hit   = host_hit | cycle_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= (INIT_CLEAR != 0) ? CLEAR : READY;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  // The fill sequencer owns the RAM write port until READY; core writes are dropped meanwhile.
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    ram_we       = 1'b0;
    ram_waddr    = word_idx;
    ram_wdata    = memwrData;
    case (state)
      CLEAR: begin
        ram_we       = 1'b1;
        ram_waddr    = clr_idx;
        ram_wdata    = '0;
        clr_idx_next = clr_idx + 1'b1;
        if (clr_idx == {DEPTH_LOG2{1'b1}}) state_next = READY;
      end
      READY: ram_we = memWE & in_ram;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    ram_q <= ram[word_idx];
  end

`ifdef DMEM_MMIO_EN
  localparam logic [ADDR_WIDTH-1:0] HOST_ADDR  = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(15);
  localparam logic [ADDR_WIDTH-1:0] CYCLE_ADDR = {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(11);

  logic [DATA_WIDTH-1:0] cycle_cnt;
  logic [DATA_WIDTH-1:0] halt_code_reg;
  logic                  halt_reg;

  assign host_hit  = (memAdr[ADDR_WIDTH-1:2] == HOST_ADDR[ADDR_WIDTH-1:2]);
  assign cycle_hit = (memAdr[ADDR_WIDTH-1:2] == CYCLE_ADDR[ADDR_WIDTH-1:2]);
  assign mmio_rd   = host_hit ? halt_code_reg : cycle_cnt;
  assign halt      = halt_reg;
  assign halt_code = halt_code_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt     <= '0;
      halt_reg      <= 1'b0;
      halt_code_reg <= '0;
    end else if (active) begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (host_hit && memWE) begin
        halt_reg      <= 1'b1;
        halt_code_reg <= memwrData;
      end
    end
  end
`else
  assign host_hit  = 1'b0;
  assign cycle_hit = 1'b0;
  assign mmio_rd   = '0;
  assign halt      = 1'b0;
  assign halt_code = '0;
`endif

  // Read source is chosen at the request edge; the RAM word itself comes from ram_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready     <= 1'b0;
      sel_ram   <= 1'b0;
      sel_mmio  <= 1'b0;
      mmio_q    <= '0;
      err_range <= 1'b0;
      err_align <= 1'b0;
    end else begin
      ready    <= (state_next == READY);
      sel_ram  <= active & ~memWE & in_ram;
      sel_mmio <= active & ~memWE & mmio_hit;
      mmio_q   <= mmio_rd;
      if (active) begin
        if (!in_ram && !mmio_hit) err_range <= 1'b1;
        if (misaligned)           err_align <= 1'b1;
      end
    end
  end

  assign memrdData = sel_ram ? ram_q : (sel_mmio ? mmio_q : '0);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder (DEPTH_LOG2=4): a per-cycle behavioural model plus directed literal checks.
// Honours DMEM_MMIO_EN the same way as the design.
module tb_dmem_responder;

  localparam int DL    = 4;
  localparam int DEPTH = 16;
`ifdef DMEM_MMIO_EN
  localparam bit MMIO = 1'b1;
`else
  localparam bit MMIO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] memAdr = '0;
  logic [31:0] memwrData = '0;
  logic        memWE = 1'b0;
  logic [31:0] memrdData;
  logic        ready, err_range, err_align, halt;
  logic [31:0] halt_code;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DEPTH_LOG2(DL),
    .INIT_CLEAR(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .memAdr(memAdr),
    .memwrData(memwrData),
    .memWE(memWE),
    .memrdData(memrdData),
    .ready(ready),
    .err_range(err_range),
    .err_align(err_align),
    .halt(halt),
    .halt_code(halt_code)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: words are zero once the fill completes, so the array is simply zeroed on reset.
  logic [31:0] m [DEPTH];
  int          since_rst;
  logic [31:0] e_rd, e_hcode, a_al;
  logic        e_ready, e_rng, e_aln, e_halt, inr, is_host, is_cyc;

  task automatic model_reset();
    since_rst = 0;
    e_rd = 0; e_ready = 0; e_rng = 0; e_aln = 0; e_halt = 0; e_hcode = 0;
    for (int i = 0; i < DEPTH; i++) m[i] = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_reset();
      end else begin
        if (since_rst < DEPTH) begin
          e_rd = 0;
        end else begin
          a_al    = memAdr & ~32'h3;
          inr     = (a_al < DEPTH * 4);
          is_host = MMIO && (a_al == 32'hFFFF_FFF0);
          is_cyc  = MMIO && (a_al == 32'hFFFF_FFF4);
          if (memWE)        e_rd = 0;
          else if (inr)     e_rd = m[a_al >> 2];
          else if (is_host) e_rd = e_hcode;
          else if (is_cyc)  e_rd = 32'(since_rst - DEPTH);
          else              e_rd = 0;
          if (memWE && inr) m[a_al >> 2] = memwrData;
          if (memWE && is_host) begin
            e_halt  = 1;
            e_hcode = memwrData;
          end
          if (!inr && !is_host && !is_cyc) e_rng = 1;
          if (memAdr[1:0] != 2'b00) e_aln = 1;
        end
        since_rst++;
        e_ready = (since_rst >= DEPTH);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_rd", memrdData, e_rd);
      check("model_ready", {31'b0, ready}, {31'b0, e_ready});
      check("model_err_range", {31'b0, err_range}, {31'b0, e_rng});
      check("model_err_align", {31'b0, err_align}, {31'b0, e_aln});
      check("model_halt", {31'b0, halt}, {31'b0, e_halt});
      check("model_halt_code", halt_code, e_hcode);
    end
  end

  task automatic acc(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memWE = we;
    memAdr = a;
    memwrData = d;
    $display("txn %s addr=0x%08h data=0x%08h", we ? "WR" : "RD", a, d);
  endtask

  // Called at the negedge where reset was just released.
  task automatic ready_after_fill(input string tag);
    for (int i = 1; i < DEPTH; i++) @(negedge clk);
    check({tag, "_ready_low_16"}, {31'b0, ready}, 32'd0);
    @(negedge clk);
    check({tag, "_ready_high_17"}, {31'b0, ready}, 32'd1);
  endtask

  logic [31:0] c1, c2;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_rd", memrdData, 32'd0);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_err_range", {31'b0, err_range}, 32'd0);
    check("rst_halt", {31'b0, halt}, 32'd0);
    reset = 1'b0;
    ready_after_fill("fill1");

    acc(0, 32'h0000_003C, 0);
    @(negedge clk);
    check("t1_rd_3c", memrdData, 32'h0);

`ifdef DMEM_MMIO_EN
    acc(1, 32'hFFFF_FFF0, 32'h1);
    @(negedge clk);
    check("t5_halt", {31'b0, halt}, 32'd1);
    check("t5_halt_code", halt_code, 32'h1);
    acc(0, 32'hFFFF_FFF0, 0);
    @(negedge clk);
    check("t5_host_rd", memrdData, 32'h1);
    acc(0, 32'hFFFF_FFF4, 0);
    @(negedge clk);
    c1 = memrdData;
    repeat (5) @(negedge clk);
    c2 = memrdData;
    check("t5_cycle_diff", c2 - c1, 32'd5);
    check("t5_no_range_err", {31'b0, err_range}, 32'd0);
`else
    acc(1, 32'hFFFF_FFF0, 32'h1);
    @(negedge clk);
    check("t5_nommio_range", {31'b0, err_range}, 32'd1);
    check("t5_nommio_halt", {31'b0, halt}, 32'd0);
`endif

    acc(1, 32'h0000_0010, 32'hDEAD_BEEF);
    acc(0, 32'h0000_0010, 0);
    @(negedge clk);
    check("t2_raw", memrdData, 32'hDEAD_BEEF);

    check("t4_align_pre", {31'b0, err_align}, 32'd0);
    acc(1, 32'h0000_0006, 32'h0000_1234);
    @(negedge clk);
    check("t4_align_set", {31'b0, err_align}, 32'd1);
    acc(0, 32'h0000_0004, 0);
    @(negedge clk);
    check("t4_word1", memrdData, 32'h0000_1234);

    acc(1, 32'h0000_0000, 32'h0000_0055);
    acc(0, 32'h0000_1000, 0);
    @(negedge clk);
    check("t3_oor_rd", memrdData, 32'h0);
    check("t3_oor_flag", {31'b0, err_range}, 32'd1);
    acc(1, 32'h0000_1000, 32'h0000_0099);
    acc(1, 32'h0000_0040, 32'h0000_0077);
    acc(1, 32'h0000_003C, 32'hCAFE_0001);
    acc(0, 32'h0000_0000, 0);
    @(negedge clk);
    check("t3_word0_kept", memrdData, 32'h0000_0055);
    acc(0, 32'h0000_003C, 0);
    @(negedge clk);
    check("t3_last_word", memrdData, 32'hCAFE_0001);
    acc(0, 32'h0000_0040, 0);
    @(negedge clk);
    check("t3_boundary_rd", memrdData, 32'h0);
    check("t3_flag_sticky", {31'b0, err_range}, 32'd1);

    @(negedge clk);
    reset = 1'b1;
    memAdr = 0; memWE = 0; memwrData = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_mid_ready", {31'b0, ready}, 32'd0);
    check("t6_mid_err_align", {31'b0, err_align}, 32'd0);
    reset = 1'b0;
    ready_after_fill("fill2");
    acc(0, 32'h0000_0010, 0);
    @(negedge clk);
    check("t6_cleared", memrdData, 32'h0);
    acc(0, 32'h0000_0000, 0);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
